image_pixel_streamer: RTL and testbench

//  Frame-source master for the three-channel line-buffer/window stage: it drives that stage's

---
 rtl/image_pixel_streamer.sv | 146 ++++++++++++++
 tb/tb_image_pixel_streamer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pixel_streamer.sv
// ---------------------------------------------------------------------------
// image_pixel_streamer
// Frame source for the three-channel line-buffer/window stage. On start it
// walks one image_size x image_size RGB frame in raster order through an
// external synchronous pixel memory and presents one pixel per cycle, with
// wr_en, to the window stage. Downstream back-pressure (hold) pauses new reads.
// No border padding is added here; that is done by the window stage.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   start               1-cycle pulse, accepted only in IDLE
//   hold                1 = issue no new memory reads
//   base_addr           frame start address, sampled on accepted start
//   mem_rd_en/mem_addr  memory read strobe and address
//   mem_rdataR/G/B      memory read data, valid 1 cycle after mem_rd_en
//   input_pixelR/G/B    registered pixel to the window stage (signed samples)
//   wr_en               1 = input_pixelR/G/B valid this cycle
//   busy                1 from the cycle after accepted start through DONE
//   frame_done          1-cycle pulse the cycle after the last pixel's wr_en
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing one read per cycle unless hold
// DRAIN  | all reads issued, waiting for the last read data to return
// DONE   | frame_done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module image_pixel_streamer #(
  parameter int image_size = 224,
  parameter int bitsize    = 14,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [bitsize-1:0]    mem_rdataR,
  input  logic [bitsize-1:0]    mem_rdataG,
  input  logic [bitsize-1:0]    mem_rdataB,
  output logic [bitsize-1:0]    input_pixelR,
  output logic [bitsize-1:0]    input_pixelG,
  output logic [bitsize-1:0]    input_pixelB,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (image_size > 1) ? $clog2(image_size) : 1;
  localparam logic [CW-1:0] LAST = CW'(image_size - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CW-1:0]           row_q, col_q;
  logic                    rd_q;     // read issued last cycle: data on mem_rdata* now
  logic                    wr_q;
  logic [bitsize-1:0]      pix_r_q, pix_g_q, pix_b_q;

  logic rd_issue;
  logic last_rd;

  assign rd_issue = (state_q == STREAM) && !hold;
  assign last_rd  = rd_issue && (row_q == LAST) && (col_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)   state_d = STREAM;
      STREAM:  if (last_rd) state_d = DRAIN;
      DRAIN:   if (!rd_q)   state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    mem_rd_en  = rd_issue;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  // Address/raster counters and the two-stage read pipeline. The address is
  // a running counter so no row*image_size multiply is needed; it wraps
  // naturally at 2**ADDR_WIDTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      pix_r_q <= '0;
      pix_g_q <= '0;
      pix_b_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_q <= base_addr;
        row_q  <= '0;
        col_q  <= '0;
      end else if (rd_issue) begin
        addr_q <= addr_q + 1'b1;
        if (col_q == LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      rd_q <= rd_issue;
      wr_q <= rd_q;
      // Pixels only update on returning data so they hold when wr_en is low.
      if (rd_q) begin
        pix_r_q <= mem_rdataR;
        pix_g_q <= mem_rdataG;
        pix_b_q <= mem_rdataB;
      end
    end
  end

  assign mem_addr     = addr_q;
  assign wr_en        = wr_q;
  assign input_pixelR = pix_r_q;
  assign input_pixelG = pix_g_q;
  assign input_pixelB = pix_b_q;

endmodule

// File: tb/tb_image_pixel_streamer.sv
module tb_image_pixel_streamer;

  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int BS = 14;
  localparam int AW = 16;
  localparam int BIGN = 224 * 224;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start_big, hold;
  logic [AW-1:0] base_addr;

  // small (4x4) instance
  logic          rd_en, wr, busy, done;
  logic [AW-1:0] addr;
  logic [BS-1:0] rR, rG, rB, pR, pG, pB;

  // full-size (224x224) instance
  logic          b_rd_en, b_wr, b_busy, b_done;
  logic [AW-1:0] b_addr;
  logic [BS-1:0] b_rR, b_rG, b_rB, b_pR, b_pG, b_pB;

  image_pixel_streamer #(.image_size(N), .bitsize(BS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .base_addr(base_addr),
    .mem_rd_en(rd_en), .mem_addr(addr),
    .mem_rdataR(rR), .mem_rdataG(rG), .mem_rdataB(rB),
    .input_pixelR(pR), .input_pixelG(pG), .input_pixelB(pB),
    .wr_en(wr), .busy(busy), .frame_done(done)
  );

  image_pixel_streamer #(.image_size(224), .bitsize(BS), .ADDR_WIDTH(AW)) dut_big (
    .clk(clk), .rst(rst), .start(start_big), .hold(1'b0), .base_addr(base_addr),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_rdataR(b_rR), .mem_rdataG(b_rG), .mem_rdataB(b_rB),
    .input_pixelR(b_pR), .input_pixelG(b_pG), .input_pixelB(b_pB),
    .wr_en(b_wr), .busy(b_busy), .frame_done(b_done)
  );

  // synchronous pixel memories: R=addr, G=-addr, B=addr+1
  always @(posedge clk) begin
    if (rd_en) begin
      rR <= addr[BS-1:0];
      rG <= -addr[BS-1:0];
      rB <= addr[BS-1:0] + 14'd1;
    end
    if (b_rd_en) begin
      b_rR <= b_addr[BS-1:0];
      b_rG <= -b_addr[BS-1:0];
      b_rB <= b_addr[BS-1:0] + 14'd1;
    end
  end

  int checks = 0;
  int errors = 0;

  int            rd_cyc[$];
  logic [AW-1:0] rd_adr[$];
  int            wr_cyc[$];
  logic [BS-1:0] wr_r[$], wr_g[$], wr_b[$];
  int            done_cyc[$];
  int            busy_cnt;

  // Runs ncyc cycles of the small instance: start at cycle 0 (and again at
  // restart_at), hold high for cycles hs..hs+hl-1. Logs every observed event.
  task automatic run_small(input int ncyc, input int hs, input int hl, input int restart_at);
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete();
    wr_r.delete(); wr_g.delete(); wr_b.delete(); done_cyc.delete();
    busy_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == restart_at);
      hold  = (c >= hs) && (c < hs + hl);
      #1;
      if (rd_en) begin rd_cyc.push_back(c); rd_adr.push_back(addr); end
      if (wr) begin
        wr_cyc.push_back(c);
        wr_r.push_back(pR); wr_g.push_back(pG); wr_b.push_back(pB);
      end
      if (done) done_cyc.push_back(c);
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic test_reset();
    logic [BS-1:0] e_r;
    int bad;
    rst = 1'b0; start = 1'b0; start_big = 1'b0; hold = 1'b0; base_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({rd_en, addr, pR, pG, pB, wr, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: rd_en=%b addr=%0d pR=%0d pG=%0d pB=%0d wr=%b busy=%b done=%b, required all 0",
               rd_en, addr, pR, pG, pB, wr, busy, done);
    end
    @(negedge clk); rst = 1'b1;
    base_addr = 16'd40;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start = (c == 0);
      #1;
    end
    start = 1'b0;
    // cycle 7: pixel 4 on the output
    e_r = 14'd44;
    checks++;
    if (busy !== 1'b1 || wr !== 1'b1 || pR !== e_r) begin
      errors++;
      $display("FAIL reset_pre_state: busy=%b wr=%b pR=%0d, required busy=1 wr=1 pR=%0d", busy, wr, pR, e_r);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({rd_en, addr, pR, pG, pB, wr, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_midframe: rd_en=%b addr=%0d pR=%0d pG=%0d pB=%0d wr=%b busy=%b done=%b, required all 0",
               rd_en, addr, pR, pG, pB, wr, busy, done);
    end
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || rd_en !== 1'b0 || wr !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle_after_release: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic test_frame();
    int bad;
    logic [BS-1:0] e_r, e_g, e_b;
    base_addr = 16'd16;
    run_small(30, -1, 0, -1);
    checks++;
    if (rd_cyc.size() != NN) begin
      errors++;
      $display("FAIL frame_read_count: %0d, required %0d", rd_cyc.size(), NN);
    end
    bad = 0;
    for (int i = 0; i < rd_cyc.size() && i < NN; i++)
      if (rd_cyc[i] != 1 + i || rd_adr[i] !== 16'(16 + i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_read_addrs: %0d bad reads (first addr %0d), required addrs 16..31 on cycles 1..16", bad, rd_adr[0]);
    end
    checks++;
    if (wr_cyc.size() != NN) begin
      errors++;
      $display("FAIL frame_wr_count: %0d, required %0d", wr_cyc.size(), NN);
    end
    bad = 0;
    for (int i = 0; i < wr_cyc.size() && i < NN; i++) if (wr_cyc[i] != 3 + i) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_wr_timing: %0d bad (first wr cycle %0d), required cycles 3..18", bad, wr_cyc[0]);
    end
    bad = 0;
    for (int i = 0; i < wr_r.size() && i < NN; i++) begin
      e_r = 14'(16 + i); e_g = -e_r; e_b = 14'(17 + i);
      if (wr_r[i] !== e_r || wr_g[i] !== e_g || wr_b[i] !== e_b) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_pixels: %0d bad pixels (pixel0 R=%0d G=%0d B=%0d), required R=16+k G=-(16+k) B=17+k",
               bad, wr_r[0], wr_g[0], wr_b[0]);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 19) begin
      errors++;
      $display("FAIL frame_done: %0d pulses first at %0d, required 1 pulse at cycle 19",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (busy_cnt != NN + 3) begin
      errors++;
      $display("FAIL frame_busy_cycles: %0d, required %0d", busy_cnt, NN + 3);
    end
  endtask

  task automatic test_hold();
    int bad, in_hold, ec;
    logic [BS-1:0] e_r;
    base_addr = 16'd16;
    // pixel 6 appears on cycle 9; hold is high cycles 9..13
    run_small(40, 9, 5, -1);
    in_hold = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= 9 && wr_cyc[i] <= 13) in_hold++;
    checks++;
    if (in_hold != 2) begin
      errors++;
      $display("FAIL hold_wr_during_hold: %0d, required 2", in_hold);
    end
    bad = 0;
    for (int i = 0; i < rd_cyc.size() && i < NN; i++) begin
      ec = (i < 8) ? 1 + i : 6 + i;
      if (rd_cyc[i] != ec || rd_adr[i] !== 16'(16 + i)) bad++;
    end
    checks++;
    if (bad != 0 || rd_cyc.size() != NN) begin
      errors++;
      $display("FAIL hold_reads: %0d reads, %0d misplaced, required 16 with none during hold", rd_cyc.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < wr_cyc.size() && i < NN; i++) begin
      ec = (i < 8) ? 3 + i : 8 + i;
      e_r = 14'(16 + i);
      if (wr_cyc[i] != ec || wr_r[i] !== e_r) bad++;
    end
    checks++;
    if (bad != 0 || wr_cyc.size() != NN) begin
      errors++;
      $display("FAIL hold_pixels: %0d pixels, %0d wrong or misplaced, required 16 in order resuming at pixel 8 on cycle 16",
               wr_cyc.size(), bad);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 24) begin
      errors++;
      $display("FAIL hold_frame_done: %0d pulses first at %0d, required 1 pulse at cycle 24",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_restart_ignored();
    int bad;
    base_addr = 16'd16;
    run_small(30, -1, 0, 5);
    bad = 0;
    for (int i = 0; i < rd_adr.size() && i < NN; i++) if (rd_adr[i] !== 16'(16 + i)) bad++;
    checks++;
    if (wr_cyc.size() != NN || rd_cyc.size() != NN || bad != 0) begin
      errors++;
      $display("FAIL restart_ignored: reads=%0d wr=%0d bad_addr=%0d, required 16 16 0",
               rd_cyc.size(), wr_cyc.size(), bad);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      errors++;
      $display("FAIL restart_frame_done: %0d pulses, required 1", done_cyc.size());
    end
  endtask

  task automatic test_addr_wrap();
    int bad;
    logic [AW-1:0] ea;
    logic [BS-1:0] e_r;
    base_addr = 16'hFFFA;
    run_small(30, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < rd_adr.size() && i < NN; i++) begin
      ea = 16'hFFFA + 16'(i);
      if (rd_adr[i] !== ea) bad++;
    end
    for (int i = 0; i < wr_r.size() && i < NN; i++) begin
      ea  = 16'hFFFA + 16'(i);
      e_r = ea[BS-1:0];
      if (wr_r[i] !== e_r) bad++;
    end
    checks++;
    if (bad != 0 || rd_adr.size() != NN || wr_r.size() != NN) begin
      errors++;
      $display("FAIL addr_wrap: reads=%0d wr=%0d bad=%0d, required 16 16 0 with addrs 65530..65535,0..9",
               rd_adr.size(), wr_r.size(), bad);
    end
  endtask

  task automatic test_full_frame();
    int wr_cnt, wr_first, wr_last, bcnt, dcnt, dcyc, rdcnt, c, after;
    logic [AW-1:0] last_addr, ea;
    logic [BS-1:0] last_r, e_r;
    wr_cnt = 0; wr_first = -1; wr_last = -1; bcnt = 0; dcnt = 0; dcyc = -1;
    rdcnt = 0; after = 0; last_addr = '0; last_r = '0;
    base_addr = 16'd100;
    c = 0;
    while (c < 51000 && after < 3) begin
      @(negedge clk);
      start_big = (c == 0);
      #1;
      if (b_rd_en) begin rdcnt++; last_addr = b_addr; end
      if (b_wr) begin
        if (wr_first < 0) wr_first = c;
        wr_last = c; wr_cnt++; last_r = b_pR;
      end
      if (b_busy) bcnt++;
      if (b_done) begin dcnt++; dcyc = c; end
      if (dcnt > 0) after++;
      c++;
    end
    start_big = 1'b0;
    checks++;
    if (dcnt == 0) begin
      errors++;
      $display("FAIL full_timeout: no frame_done within %0d cycles", c);
    end
    checks++;
    if (wr_cnt != BIGN || wr_first != 3 || wr_last - wr_first + 1 != BIGN) begin
      errors++;
      $display("FAIL full_wr: count=%0d first=%0d last=%0d, required %0d consecutive from cycle 3",
               wr_cnt, wr_first, wr_last, BIGN);
    end
    checks++;
    if (bcnt != BIGN + 3) begin
      errors++;
      $display("FAIL full_busy_cycles: %0d, required %0d", bcnt, BIGN + 3);
    end
    ea  = 16'(100 + BIGN - 1);
    e_r = ea[BS-1:0];
    checks++;
    if (rdcnt != BIGN || last_addr !== ea || last_r !== e_r) begin
      errors++;
      $display("FAIL full_last_addr: reads=%0d last_addr=%0d last_R=%0d, required %0d %0d %0d",
               rdcnt, last_addr, last_r, BIGN, ea, e_r);
    end
    checks++;
    if (dcnt != 1 || dcyc != wr_last + 1) begin
      errors++;
      $display("FAIL full_frame_done: %0d pulses at %0d, required 1 at %0d", dcnt, dcyc, wr_last + 1);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_restart_ignored();
    test_addr_wrap();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
